// File: rtl/spike_frame_deserializer_if.sv
//------------------------------------------------------------------------------
// Module  : spike_frame_deserializer_if
// Brief   : Serial spike link input and completed-frame valid/ready output bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spike_frame_deserializer_if #(
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 8
);
    localparam int POP_W = $clog2(FRAME_W) + 1;

    logic               serial_in;
    logic               serial_valid;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_data;
    logic [POP_W-1:0]   frame_popcnt;
    logic               frame_valid;
    logic               frame_ready;
    logic               busy;
    logic               drop;
    logic               sync_err;
    logic [CNT_W-1:0]   overflow_cnt;

    // The deserializer side
    modport slave (
        input  serial_in,
        input  serial_valid,
        input  frame_start,
        input  frame_ready,
        output frame_data,
        output frame_popcnt,
        output frame_valid,
        output busy,
        output drop,
        output sync_err,
        output overflow_cnt
    );

    // The link driver / frame consumer side
    modport master (
        output serial_in,
        output serial_valid,
        output frame_start,
        output frame_ready,
        input  frame_data,
        input  frame_popcnt,
        input  frame_valid,
        input  busy,
        input  drop,
        input  sync_err,
        input  overflow_cnt
    );
endinterface

`default_nettype wire

// File: rtl/spike_frame_deserializer.sv
//------------------------------------------------------------------------------
// Module  : spike_frame_deserializer
// Brief   : Rebuilds MSB-first serial spike frames, tags them with a popcount
//           and buffers them in a small valid/ready FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_frame_deserializer #(
    parameter int FRAME_W    = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    spike_frame_deserializer_if.slave link
);
    localparam int POP_W = $clog2(FRAME_W) + 1;
    localparam int BC_W  = $clog2(FRAME_W) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BC_W-1:0]  c_LAST_BIT = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0]  c_ONE_BIT  = BC_W'(1);
    localparam logic [OCC_W-1:0] c_FULL     = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [BC_W-1:0]    r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic               r_busy;
    logic               r_sync_err;
    logic               r_drop;
    logic [CNT_W-1:0]   r_overflow_cnt;

    logic [FRAME_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [POP_W-1:0]   r_mem_pop  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;

    logic               w_complete;
    logic [FRAME_W-1:0] w_frame;
    logic [POP_W-1:0]   w_frame_popcnt;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    function automatic logic [POP_W-1:0] f_popcount(input logic [FRAME_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Last bit of a frame: the full frame is the shifted partial plus this bit,
    // so it can be pushed on the very edge that accepts it.
    assign w_complete     = (r_state == S_SHIFT) && link.serial_valid &&
                            !link.frame_start && (r_bit_cnt == c_LAST_BIT);
    assign w_frame        = {r_shift[FRAME_W-2:0], link.serial_in};
    assign w_frame_popcnt = f_popcount(w_frame);

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == c_FULL);
    assign w_pop   = !w_empty && link.frame_ready;
    assign w_push  = w_complete && (!w_full || w_pop);
    assign w_drop  = w_complete && w_full && !w_pop;

    // Frame assembly FSM. The partial frame is kept right-aligned so the first
    // bit lands in the MSB after FRAME_W-1 further shifts.
    always_ff @(negedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_busy         <= 1'b0;
            r_sync_err     <= 1'b0;
            r_drop         <= 1'b0;
            r_overflow_cnt <= '0;
        end else begin
            r_sync_err <= 1'b0;
            r_drop     <= w_drop;
            if (w_drop && (r_overflow_cnt != c_CNT_MAX)) begin
                r_overflow_cnt <= r_overflow_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (link.serial_valid && link.frame_start) begin
                        r_shift   <= {{(FRAME_W-1){1'b0}}, link.serial_in};
                        r_bit_cnt <= c_ONE_BIT;
                        r_state   <= S_SHIFT;
                        r_busy    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (link.serial_valid) begin
                        if (link.frame_start) begin
                            // Resynchronise: drop the partial, this bit opens a new frame
                            r_sync_err <= 1'b1;
                            r_shift    <= {{(FRAME_W-1){1'b0}}, link.serial_in};
                            r_bit_cnt  <= c_ONE_BIT;
                        end else if (r_bit_cnt == c_LAST_BIT) begin
                            r_shift   <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_shift   <= w_frame;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bit_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset: emptiness is tracked by occupancy alone.
    always_ff @(negedge clock) begin
        if (w_push && !reset) begin
            r_mem_data[r_wr_ptr] <= w_frame;
            r_mem_pop[r_wr_ptr]  <= w_frame_popcnt;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    assign link.frame_data   = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign link.frame_popcnt = w_empty ? '0 : r_mem_pop[r_rd_ptr];
    assign link.frame_valid  = !w_empty;
    assign link.busy         = r_busy;
    assign link.drop         = r_drop;
    assign link.sync_err     = r_sync_err;
    assign link.overflow_cnt = r_overflow_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spike_frame_deserializer.sv
//------------------------------------------------------------------------------
// Module  : tb_spike_frame_deserializer
// Brief   : Directed stimulus with a queue-based scoreboard for the deserializer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_frame_deserializer;
    localparam int FRAME_W    = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 8;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  pc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    spike_frame_deserializer_if #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) link ();

    spike_frame_deserializer #(
        .FRAME_W   (FRAME_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .link (link)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Inputs change on posedge; the DUT consumes them on the following negedge.
    task automatic drive(input logic b, input logic v, input logic fs);
        @(posedge clock);
        link.serial_in    = b;
        link.serial_valid = v;
        link.frame_start  = fs;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] f, input bit stall);
        for (int i = 15; i >= 0; i--) begin
            drive(f[i], 1'b1, i == 15);
            if (stall && i != 0) begin
                drive(1'b0, 1'b0, 1'b0);
                #3 check("busy_stall", 32'(link.busy), 32'd1);
            end
        end
    endtask

    // Monitor: a handshake seen between posedge and the next negedge is a pop.
    always @(posedge clock) begin
        exp_t e;
        #3;
        if (link.frame_valid === 1'b1 && link.frame_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got %0h required none", link.frame_data);
            end else begin
                e = exp_q.pop_front();
                check("frame_data", 32'(link.frame_data), 32'(e.data));
                check("frame_popcnt", 32'(link.frame_popcnt), 32'(e.pc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        link.serial_in    = 1'b0;
        link.serial_valid = 1'b0;
        link.frame_start  = 1'b0;
        link.frame_ready  = 1'b0;

        // 1 reset
        repeat (2) @(negedge clock);
        @(posedge clock);
        reset = 1'b0;
        #3;
        check("rst_frame_valid", 32'(link.frame_valid), 32'd0);
        check("rst_busy", 32'(link.busy), 32'd0);
        check("rst_drop", 32'(link.drop), 32'd0);
        check("rst_sync_err", 32'(link.sync_err), 32'd0);
        check("rst_overflow", 32'(link.overflow_cnt), 32'd0);
        check("rst_frame_data", 32'(link.frame_data), 32'd0);
        check("rst_popcnt", 32'(link.frame_popcnt), 32'd0);

        // 2 single frame, zero latency
        link.frame_ready = 1'b1;
        exp_q.push_back('{data: 16'hA5C3, pc: 5'd8});
        send_frame(16'hA5C3, 1'b0);
        #8;
        check("t2_valid_after_last", 32'(link.frame_valid), 32'd1);
        check("t2_busy_done", 32'(link.busy), 32'd0);
        idle(3);

        // 3 stalled frame
        exp_q.push_back('{data: 16'hFFFF, pc: 5'd16});
        send_frame(16'hFFFF, 1'b1);
        idle(3);

        // 4 overflow with consumer stalled
        link.frame_ready = 1'b0;
        exp_q.push_back('{data: 16'h0001, pc: 5'd1});
        exp_q.push_back('{data: 16'h8000, pc: 5'd1});
        send_frame(16'h0001, 1'b0);
        send_frame(16'h8000, 1'b0);
        send_frame(16'h1234, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #3;
        check("t4_drop", 32'(link.drop), 32'd1);
        check("t4_overflow", 32'(link.overflow_cnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        #3;
        check("t4_drop_pulse", 32'(link.drop), 32'd0);
        check("t4_hold_data", 32'(link.frame_data), 32'h0001);
        check("t4_hold_valid", 32'(link.frame_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        link.frame_ready = 1'b1;
        idle(4);
        #3;
        check("t4_empty_valid", 32'(link.frame_valid), 32'd0);
        check("t4_empty_data", 32'(link.frame_data), 32'd0);

        // 5 resync mid-frame
        drive(1'b1, 1'b1, 1'b1);
        repeat (7) drive(1'b1, 1'b1, 1'b0);
        exp_q.push_back('{data: 16'h0F0F, pc: 5'd8});
        for (int i = 15; i >= 0; i--) begin
            drive(16'h0F0F >> i, 1'b1, i == 15);
            if (i == 15) begin
                #8;
                check("t5_sync_err", 32'(link.sync_err), 32'd1);
                check("t5_busy", 32'(link.busy), 32'd1);
                check("t5_no_partial", 32'(link.frame_valid), 32'd0);
            end else if (i == 14) begin
                #8 check("t5_sync_err_pulse", 32'(link.sync_err), 32'd0);
            end
        end
        idle(3);

        // 6 push and pop on the same edge while full, then reset mid-frame
        link.frame_ready = 1'b0;
        exp_q.push_back('{data: 16'h1111, pc: 5'd4});
        exp_q.push_back('{data: 16'h2222, pc: 5'd4});
        send_frame(16'h1111, 1'b0);
        send_frame(16'h2222, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            drive(16'h00FF >> i, 1'b1, i == 15);
            if (i == 0) link.frame_ready = 1'b1;
        end
        drive(1'b0, 1'b0, 1'b0);
        link.frame_ready = 1'b0;
        #3;
        check("t6_no_drop", 32'(link.drop), 32'd0);
        check("t6_overflow", 32'(link.overflow_cnt), 32'd1);
        check("t6_head", 32'(link.frame_data), 32'h2222);
        drive(1'b0, 1'b0, 1'b0);
        link.frame_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        link.frame_ready = 1'b0;
        #3;
        check("t6_00ff_data", 32'(link.frame_data), 32'h00FF);
        check("t6_00ff_popcnt", 32'(link.frame_popcnt), 32'd8);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        #8 check("t6_busy_mid", 32'(link.busy), 32'd1);
        drive(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #3;
        check("t6_rst_valid", 32'(link.frame_valid), 32'd0);
        check("t6_rst_busy", 32'(link.busy), 32'd0);
        check("t6_rst_data", 32'(link.frame_data), 32'd0);
        check("t6_rst_overflow", 32'(link.overflow_cnt), 32'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
